// File: rtl/matched_filter_peak_detect.sv
// Complex |x|^2 pipeline with windowed peak search and one-cycle report.
// Optional threshold qualification via `define PEAK_THRESHOLD_EN.
module matched_filter_peak_detect #(
  parameter int DATA_WIDTH    = 21,
  parameter int WINDOW_LENGTH = 64,
  parameter int INDEX_WIDTH   = 6
) (
  input  logic                         clock,
  input  logic                         nReset,
  input  logic                         startFlag,
  input  logic                         dataValid,
  input  logic signed [DATA_WIDTH-1:0] dataInRe,
  input  logic signed [DATA_WIDTH-1:0] dataInIm,
`ifdef PEAK_THRESHOLD_EN
  input  logic [2*DATA_WIDTH:0]        threshold,
`endif
  output logic [2*DATA_WIDTH:0]        peakMagnitude,
  output logic [INDEX_WIDTH-1:0]       peakIndex,
  output logic                         peakValidFlag,
  output logic                         busyFlag,
  output logic                         detectFlag
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int MW = 2 * DATA_WIDTH + 1;
  localparam logic [INDEX_WIDTH-1:0] LAST =
    INDEX_WIDTH'(WINDOW_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    REPORT
  } state_t;

  state_t                  state_q, state_d;
  logic signed [PW-1:0]    re_sq_q, re_sq_d;
  logic signed [PW-1:0]    im_sq_q, im_sq_d;
  logic                    vld1_q, vld1_d;
  logic [MW-1:0]           mag_q, mag_d;
  logic                    mag_vld_q, mag_vld_d;
  logic [MW-1:0]           max_q, max_d;
  logic [INDEX_WIDTH-1:0]  idx_q, idx_d;
  logic [INDEX_WIDTH-1:0]  cnt_q, cnt_d;
  logic [MW-1:0]           pk_mag_q, pk_mag_d;
  logic [INDEX_WIDTH-1:0]  pk_idx_q, pk_idx_d;
  logic                    pk_vld_q, pk_vld_d;
  logic                    det_q, det_d;
  logic signed [PW-1:0]    re_x, im_x;
  logic                    det_hit;

  // Two-stage magnitude pipeline; squares are non-negative so the
  // zero-extended sum is exact.
  always_comb begin
    re_x      = {{DATA_WIDTH{dataInRe[DATA_WIDTH-1]}}, dataInRe};
    im_x      = {{DATA_WIDTH{dataInIm[DATA_WIDTH-1]}}, dataInIm};
    re_sq_d   = re_x * re_x;
    im_sq_d   = im_x * im_x;
    vld1_d    = dataValid;
    mag_d     = {1'b0, re_sq_q} + {1'b0, im_sq_q};
    mag_vld_d = vld1_q;
  end

`ifdef PEAK_THRESHOLD_EN
  assign det_hit = (max_q > threshold);
`else
  assign det_hit = 1'b1;
`endif

  // Search FSM: next state, running max/index/count and report loads.
  always_comb begin
    state_d  = state_q;
    max_d    = max_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    pk_mag_d = pk_mag_q;
    pk_idx_d = pk_idx_q;
    det_d    = det_q;
    pk_vld_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (startFlag) begin
          state_d = SEARCH;
          max_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      SEARCH: begin
        if (mag_vld_q) begin
          if (mag_q > max_q) begin
            max_d = mag_q;
            idx_d = cnt_q;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = REPORT;
          end
        end
      end
      REPORT: begin
        pk_mag_d = max_q;
        pk_idx_d = idx_q;
        det_d    = det_hit;
        pk_vld_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, all cleared by async reset.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      re_sq_q   <= '0;
      im_sq_q   <= '0;
      vld1_q    <= 1'b0;
      mag_q     <= '0;
      mag_vld_q <= 1'b0;
      max_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      pk_mag_q  <= '0;
      pk_idx_q  <= '0;
      pk_vld_q  <= 1'b0;
      det_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      re_sq_q   <= re_sq_d;
      im_sq_q   <= im_sq_d;
      vld1_q    <= vld1_d;
      mag_q     <= mag_d;
      mag_vld_q <= mag_vld_d;
      max_q     <= max_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pk_mag_q  <= pk_mag_d;
      pk_idx_q  <= pk_idx_d;
      pk_vld_q  <= pk_vld_d;
      det_q     <= det_d;
    end
  end

  assign peakMagnitude = pk_mag_q;
  assign peakIndex     = pk_idx_q;
  assign peakValidFlag = pk_vld_q;
  assign detectFlag    = det_q;
  assign busyFlag      = (state_q != IDLE);

endmodule

// File: tb/tb_matched_filter_peak_detect.sv
// Bench for matched_filter_peak_detect: vector table, corner
// sequences and random windows against a reference model.
module tb_matched_filter_peak_detect;

  localparam int DW = 21;
  localparam int WL = 8;
  localparam int IW = 3;
  localparam int MW = 2 * DW + 1;

  typedef struct {
    logic [WL-1:0][DW-1:0] re;
    logic [WL-1:0][DW-1:0] im;
    logic [MW-1:0]         mag;
    logic [IW-1:0]         idx;
    bit                    gaps;
    bit                    restart;
  } vec_t;

  logic                 clock = 1'b0;
  logic                 nReset = 1'b0;
  logic                 startFlag = 1'b0;
  logic                 dataValid = 1'b0;
  logic signed [DW-1:0] dataInRe = '0;
  logic signed [DW-1:0] dataInIm = '0;
  logic [MW-1:0]        peakMagnitude;
  logic [IW-1:0]        peakIndex;
  logic                 peakValidFlag;
  logic                 busyFlag;
  logic                 detectFlag;
`ifdef PEAK_THRESHOLD_EN
  logic [MW-1:0]        threshold = MW'(30);
`endif

  int total = 0;
  int bad = 0;
  vec_t tbl[6];

  matched_filter_peak_detect #(
    .DATA_WIDTH(DW),
    .WINDOW_LENGTH(WL),
    .INDEX_WIDTH(IW)
  ) dut (
    .clock(clock),
    .nReset(nReset),
    .startFlag(startFlag),
    .dataValid(dataValid),
    .dataInRe(dataInRe),
    .dataInIm(dataInIm),
`ifdef PEAK_THRESHOLD_EN
    .threshold(threshold),
`endif
    .peakMagnitude(peakMagnitude),
    .peakIndex(peakIndex),
    .peakValidFlag(peakValidFlag),
    .busyFlag(busyFlag),
    .detectFlag(detectFlag)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic logic exp_det(input logic [MW-1:0] m);
`ifdef PEAK_THRESHOLD_EN
    return (m > threshold);
`else
    return (m == m) ? 1'b1 : 1'b1;
`endif
  endfunction

  // Reference: |x|^2 in plain integer arithmetic, strict max, earliest.
  task automatic ref_peak(inout vec_t v);
    longint best = 0;
    int bi = 0;
    for (int i = 0; i < WL; i++) begin
      longint r = longint'($signed(v.re[i]));
      longint q = longint'($signed(v.im[i]));
      longint s = r * r + q * q;
      if (s > best) begin
        best = s;
        bi = i;
      end
    end
    v.mag = MW'(best);
    v.idx = IW'(bi);
  endtask

  task automatic apply(input vec_t v, input string tag);
    int lat = 0;
    int pulses = 0;
    logic [MW-1:0] m = '0;
    logic [IW-1:0] ix = '0;
    logic d = 1'b0;
    logic busy_mid = 1'b0;
    logic busy_after = 1'b1;
    @(negedge clock);
    startFlag = 1'b1;
    @(negedge clock);
    startFlag = 1'b0;
    for (int i = 0; i < WL; i++) begin
      if (v.gaps) begin
        dataValid = 1'b0;
        startFlag = 1'b0;
        dataInRe = DW'($urandom);
        dataInIm = DW'($urandom);
        @(negedge clock);
      end
      dataValid = 1'b1;
      dataInRe = v.re[i];
      dataInIm = v.im[i];
      startFlag = v.restart && (i == 3 || i == 5);
      @(negedge clock);
    end
    dataValid = 1'b0;
    startFlag = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 2) busy_mid = busyFlag;
      if (lat != 0 && k == lat + 1) busy_after = busyFlag;
      if (peakValidFlag) begin
        pulses++;
        if (lat == 0) begin
          lat = k;
          m = peakMagnitude;
          ix = peakIndex;
          d = detectFlag;
        end
      end
    end
    chk({tag, " latency"}, 64'(lat), 64'd3);
    chk({tag, " pulses"}, 64'(pulses), 64'd1);
    chk({tag, " mag"}, 64'(m), 64'(v.mag));
    chk({tag, " idx"}, 64'(ix), 64'(v.idx));
    chk({tag, " detect"}, 64'(d), 64'(exp_det(v.mag)));
    chk({tag, " busy_mid"}, 64'(busy_mid), 64'd1);
    chk({tag, " busy_after"}, 64'(busy_after), 64'd0);
    chk({tag, " mag_hold"}, 64'(peakMagnitude), 64'(v.mag));
  endtask

  initial begin
    int pulses;
    vec_t v;

    // Table: zero everything, then fill per-entry patterns.
    for (int t = 0; t < 6; t++) begin
      tbl[t].re = '0;
      tbl[t].im = '0;
      tbl[t].gaps = 1'b0;
      tbl[t].restart = 1'b0;
    end
    for (int i = 0; i < WL; i++) begin
      tbl[0].re[i] = DW'(1);
      tbl[0].im[i] = DW'(1);
      tbl[2].re[i] = DW'(2);
      tbl[2].im[i] = DW'(-2);
      tbl[4].re[i] = DW'(3);
      tbl[4].im[i] = DW'(4);
      tbl[5].re[i] = DW'(1);
    end
    tbl[0].re[5] = DW'(3);
    tbl[0].im[5] = DW'(4);
    tbl[0].mag = MW'(25);
    tbl[0].idx = 3'd5;
    tbl[1].re[2] = DW'(-1048576);
    tbl[1].re[6] = DW'(-1048576);
    tbl[1].mag = MW'(64'd1099511627776);
    tbl[1].idx = 3'd2;
    tbl[2].re[4] = DW'(-6);
    tbl[2].im[4] = DW'(5);
    tbl[2].mag = MW'(61);
    tbl[2].idx = 3'd4;
    tbl[2].gaps = 1'b1;
    tbl[2].restart = 1'b1;
    tbl[3].mag = MW'(0);
    tbl[3].idx = 3'd0;
    tbl[4].mag = MW'(25);
    tbl[4].idx = 3'd0;
    tbl[5].re[7] = DW'(5);
    tbl[5].im[7] = DW'(5);
    tbl[5].mag = MW'(50);
    tbl[5].idx = 3'd7;

    repeat (2) @(negedge clock);
    chk("rst mag", 64'(peakMagnitude), 64'd0);
    chk("rst busy", 64'(busyFlag), 64'd0);
    chk("rst valid", 64'(peakValidFlag), 64'd0);
    nReset = 1'b1;

    for (int t = 0; t < 6; t++) begin
      apply(tbl[t], $sformatf("vec%0d", t));
    end

    // Async reset mid-clock clears outputs with no edge.
    @(negedge clock);
    #2 nReset = 1'b0;
    #1;
    chk("areset mag", 64'(peakMagnitude), 64'd0);
    chk("areset idx", 64'(peakIndex), 64'd0);
    chk("areset det", 64'(detectFlag), 64'd0);
    chk("areset busy", 64'(busyFlag), 64'd0);
    @(negedge clock);
    nReset = 1'b1;

    // Reset partway through a window abandons it.
    @(negedge clock);
    startFlag = 1'b1;
    @(negedge clock);
    startFlag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dataValid = 1'b1;
      dataInRe = DW'(9);
      dataInIm = DW'(9);
      @(negedge clock);
    end
    chk("midrst busy_pre", 64'(busyFlag), 64'd1);
    #1 nReset = 1'b0;
    #1 chk("midrst busy_now", 64'(busyFlag), 64'd0);
    @(negedge clock);
    nReset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (peakValidFlag) pulses++;
    end
    dataValid = 1'b0;
    chk("midrst pulses", 64'(pulses), 64'd0);
    chk("midrst mag", 64'(peakMagnitude), 64'd0);
    chk("midrst busy", 64'(busyFlag), 64'd0);

    // Random windows checked against the reference model.
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < WL; i++) begin
        if ($urandom_range(0, 1) == 0) begin
          v.re[i] = DW'($urandom);
          v.im[i] = DW'($urandom);
        end else begin
          v.re[i] = DW'(int'($urandom_range(0, 6)) - 3);
          v.im[i] = DW'(int'($urandom_range(0, 6)) - 3);
        end
      end
      v.gaps = 1'($urandom_range(0, 1));
      v.restart = 1'($urandom_range(0, 1));
      ref_peak(v);
      apply(v, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/matched_filter_peak_detect.md
MATCHED_FILTER_PEAK_DETECT -- requirements
Module: matched_filter_peak_detect

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 21: width of signed complex input components.
REQ-002 The block SHALL have parameter WINDOW_LENGTH, default 64: valid magnitudes per search window (>=2).
REQ-003 The block SHALL have parameter INDEX_WIDTH, default 6: width of peakIndex, equal to clog2(WINDOW_LENGTH).
REQ-004 The block SHALL run on one clock; reset SHALL be asynchronous and active-low.
REQ-005 Port clock, input, 1: rising-edge system clock.
REQ-006 Port nReset, input, 1: asynchronous active-low reset.
REQ-007 Port startFlag, input, 1: arms a search window; sampled only in IDLE.
REQ-008 Port dataValid, input, 1: qualifies dataInRe/dataInIm this cycle.
REQ-009 Port dataInRe and port dataInIm, input, DATA_WIDTH each, signed: complex FIR output sample.
REQ-010 Port peakMagnitude, output, 2*DATA_WIDTH+1, unsigned: largest |x|^2 of the last completed window.
REQ-011 Port peakIndex, output, INDEX_WIDTH: window position (0-based) of peakMagnitude.
REQ-012 Port peakValidFlag, output, 1: one-cycle pulse when a window result is presented.
REQ-013 Port busyFlag, output, 1: high whenever the FSM is not in IDLE.
REQ-014 Port detectFlag, output, 1: qualifies the reported peak (see Configuration).

Function
REQ-015 Magnitude pipeline SHALL be 2 stages: stage 1 registers re*re and im*im (signed, 2*DATA_WIDTH); stage 2 registers their sum (2*DATA_WIDTH+1, unsigned); no truncation or saturation.
REQ-016 dataValid SHALL be delayed 2 cycles alongside the data as magValid; the pipeline SHALL advance every cycle regardless of FSM state.
REQ-017 FSM states SHALL be IDLE, SEARCH, REPORT.
REQ-018 IDLE -> SEARCH on startFlag=1; entering SEARCH clears the running maximum, the running index, and the sample counter to 0.
REQ-019 In SEARCH, each magValid cycle: if magnitude > running max (strict), update max and index = counter; counter increments.
REQ-020 Ties SHALL keep the earliest index.
REQ-021 SEARCH -> REPORT on the magValid cycle where counter = WINDOW_LENGTH-1; that sample SHALL participate in the comparison.
REQ-022 REPORT SHALL last one cycle: peakMagnitude/peakIndex load from the running max/index, peakValidFlag=1; next state IDLE.
REQ-023 Latency: peakValidFlag SHALL assert exactly 3 cycles after the clock edge sampling the WINDOW_LENGTH-th valid input.
REQ-024 startFlag in SEARCH or REPORT SHALL be ignored; magValid cycles in IDLE SHALL be discarded.
REQ-025 peakMagnitude/peakIndex/detectFlag SHALL hold their values until the next REPORT.
REQ-026 busyFlag SHALL be high in SEARCH and REPORT.

Reset
REQ-027 On nReset=0 all outputs, pipeline registers, magValid, counter and running max SHALL clear to 0 and the FSM SHALL enter IDLE immediately.
REQ-028 Reset mid-SEARCH SHALL abandon the window with no peakValidFlag pulse.

Configuration
REQ-029 Macro PEAK_THRESHOLD_EN defined: input port threshold (2*DATA_WIDTH+1, unsigned) exists; in REPORT detectFlag loads 1 if running max > threshold, else 0.
REQ-030 PEAK_THRESHOLD_EN undefined: no threshold port; detectFlag loads 1 at every REPORT.

Verification (bench uses WINDOW_LENGTH=8, INDEX_WIDTH=3, DATA_WIDTH=21)
REQ-031 Reset: assert nReset=0 mid-clock -> all outputs 0, busyFlag 0, without waiting for a clock edge.
REQ-032 Basic: start, 8 consecutive valid samples (1,1) except index 5 = (3,4) -> peakMagnitude 25, peakIndex 5, peakValidFlag single pulse 3 cycles after 8th sample, busyFlag falls after the pulse.
REQ-033 Extreme/tie: (-1048576,0) at indices 2 and 6, others (0,0) -> peakMagnitude 1099511627776, peakIndex 2.
REQ-034 Gaps and ignored start: dataValid alternating 1/0, startFlag pulsed again mid-window -> report after the 8th valid sample only, index counts valid samples only.
REQ-035 Reset mid-window: nReset low after 4 valid samples, then release -> no peakValidFlag, peakMagnitude stays 0, FSM IDLE.
REQ-036 Threshold (PEAK_THRESHOLD_EN defined): threshold=30, peak (3,4) -> detectFlag 0; peak (5,5) -> detectFlag 1; with the macro undefined -> detectFlag 1 in both cases.
